// File: rtl/rv_instr_pkg.sv
// rtl/rv_instr_pkg.sv - shared RV32IM field types, opcodes and immediate range helper
package rv_instr_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  // fmt is kept as raw bits so the illegal codes 6/7 survive into the encoder
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } instr_fields_t;

  // True when imm is representable as a signed value of the given bit width
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned bits);
    logic [31:0] hi;
    hi = 32'($signed(imm) >>> (bits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - combinational RV32IM field-to-word encoder with range/alignment error
module instr_encoder
  import rv_instr_pkg::*;
(
  input  instr_fields_t fields,
  output logic [31:0]   word,
  output logic          err
);

  logic [31:0] imm;
  assign imm = fields.imm;

  // Out-of-range immediates are silently truncated; only err reports them
  always_comb begin
    word = NOP_WORD;
    err  = 1'b0;
    case (fields.fmt)
      FMT_R: word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, fields.opcode};
      FMT_I: begin
        word = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
        err  = !imm_fits(imm, 12);
      end
      FMT_S: begin
        word = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0], fields.opcode};
        err  = !imm_fits(imm, 12);
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3, imm[4:1], imm[11],
                fields.opcode};
        err  = imm[0] || !imm_fits(imm, 13);
      end
      FMT_U: word = {imm[31:12], fields.rd, fields.opcode};
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
        err  = imm[0] || !imm_fits(imm, 21);
      end
      default: begin
        word = NOP_WORD;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_packer.sv
// rtl/instr_packer.sv - packs field bundles into RV32IM words and streams them with addresses
module instr_packer
  import rv_instr_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [31:0]      out_addr,
  output logic             done,
  output logic             err,
  output logic             busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_FILL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;

  state_e           state;
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fill;
  logic [CNT_W-1:0] cnt_cap;
  logic [CNT_W-1:0] accepted;
  logic [CNT_W-1:0] emitted;
  logic [31:0]      base_q;

  instr_fields_t fields;
  logic [31:0]   enc_word;
  logic          enc_err;
  logic          push;
  logic          pop;
  logic          full;

  assign fields = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                    funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  instr_encoder u_encoder (
    .fields (fields),
    .word   (enc_word),
    .err    (enc_err)
  );

  // Ready depends only on local state, never on out_ready
  assign full      = (fill == FULL_FILL);
  assign in_ready  = (state == S_RUN) && !full && (accepted < cnt_cap);
  assign out_valid = (fill != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];
  assign out_addr  = base_q + (32'(emitted) << 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      cnt_cap  <= '0;
      accepted <= '0;
      emitted  <= '0;
      base_q   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      done <= 1'b0;

      if (push) begin
        mem[wr_ptr] <= enc_word;
        wr_ptr      <= wr_ptr + 1'b1;
        accepted    <= accepted + 1'b1;
        if (enc_err) err <= 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        emitted <= emitted + 1'b1;
      end
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase

      case (state)
        S_IDLE: begin
          if (start) begin
            err      <= 1'b0;
            accepted <= '0;
            emitted  <= '0;
            base_q   <= base_addr;
            cnt_cap  <= count;
            if (count != '0) begin
              state <= S_RUN;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (push && (accepted + 1'b1 == cnt_cap)) state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (pop && (emitted + 1'b1 == cnt_cap)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_packer.sv
// tb/tb_instr_packer.sv - table-driven and sequence checks for instr_packer
module tb_instr_packer;
  import rv_instr_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      base_addr = '0;
  logic [CNT_W-1:0] count = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_fmt = '0;
  logic [6:0]       in_opcode = '0;
  logic [4:0]       in_rd = '0;
  logic [4:0]       in_rs1 = '0;
  logic [4:0]       in_rs2 = '0;
  logic [2:0]       in_funct3 = '0;
  logic [6:0]       in_funct7 = '0;
  logic [31:0]      in_imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [31:0]      out_addr;
  logic             done;
  logic             err;
  logic             busy;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] word;
    logic        err;
    string       name;
  } vec_t;

  vec_t vecs [16];

  always #5 clk = ~clk;

  instr_packer #(.FIFO_DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fields(input vec_t v);
    in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
  endtask

  task automatic set_addi(input int k);
    in_fmt = FMT_I; in_opcode = OP_OP_IMM; in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'(k);
  endtask

  // One-word load of vector v; checks latency, word, address, done timing and err
  task automatic run_one(input vec_t v, input logic [31:0] base);
    int n;
    start = 1'b1; base_addr = base; count = 16'd1;
    step();
    start = 1'b0;
    chk({v.name, "_busy"}, busy, 1);
    chk({v.name, "_err_clr"}, err, 0);
    drive_fields(v);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin step(); n++; end
    chk({v.name, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    chk({v.name, "_out_valid"}, out_valid, 1);
    chk({v.name, "_data"}, out_data, v.word);
    chk({v.name, "_addr"}, out_addr, base);
    chk({v.name, "_ready_after"}, in_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({v.name, "_done"}, done, 1);
    chk({v.name, "_err"}, err, v.err);
    step();
    chk({v.name, "_done_low"}, done, 0);
    chk({v.name, "_idle"}, busy, 0);
    chk({v.name, "_err_sticky"}, err, v.err);
  endtask

  // Streams ADDI x1,x0,k words (k = index) until n_total popped; acc words already pushed
  task automatic stream(input int acc_in, input int n_total, input logic [31:0] base,
                        input string tag);
    int acc, pops, dones;
    logic p, a;
    logic [31:0] exp_addr;
    acc = acc_in; pops = 0; dones = 0;
    set_addi(acc);
    in_valid = (acc < n_total);
    out_ready = 1'b1;
    for (int c = 0; c < 60 && pops < n_total; c++) begin
      p = out_valid && out_ready;
      a = in_valid && in_ready;
      if (p) begin
        exp_addr = base + 32'(4 * pops);
        chk({tag, "_data"}, out_data, (32'(pops) << 20) | 32'h93);
        chk({tag, "_addr"}, out_addr, exp_addr);
      end
      step();
      if (p) pops++;
      if (a) begin
        acc++;
        if (acc == n_total) in_valid = 1'b0;
        else set_addi(acc);
      end
      if (done) dones++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (done) dones++;
    end
    chk({tag, "_pops"}, pops, n_total);
    chk({tag, "_done_count"}, dones, 1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    logic a;

    vecs[0]  = '{FMT_U, OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0, "lui"};
    vecs[1]  = '{FMT_I, OP_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000001, 32'h00100093, 1'b0, "addi"};
    vecs[2]  = '{FMT_S, OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h00000004, 32'h0020A223, 1'b0, "sw"};
    vecs[3]  = '{FMT_J, OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000008, 32'h008000EF, 1'b0, "jal"};
    vecs[4]  = '{FMT_R, 7'h33,     5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000000, 32'h002081B3, 1'b0, "add"};
    vecs[5]  = '{FMT_R, 7'h33,     5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 32'h402081B3, 1'b0, "sub"};
    vecs[6]  = '{FMT_R, 7'h33,     5'd3, 5'd1, 5'd2, 3'd0, 7'h01, 32'h00000000, 32'h022081B3, 1'b0, "mul"};
    vecs[7]  = '{FMT_I, OP_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF00093, 1'b0, "addi_m1"};
    vecs[8]  = '{FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0, "beq_m4"};
    vecs[9]  = '{3'd7,  7'h33,     5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000000, 32'h00000013, 1'b1, "fmt7"};
    vecs[10] = '{FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000003, 32'h00208163, 1'b1, "beq_odd"};
    vecs[11] = '{FMT_I, OP_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h80000093, 1'b1, "addi_big"};
    vecs[12] = '{FMT_J, OP_JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00100000, 32'h8000006F, 1'b1, "jal_big"};
    vecs[13] = '{FMT_U, OP_AUIPC,  5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'hABCDEFFF, 32'hABCDE517, 1'b0, "auipc_low"};
    vecs[14] = '{3'd6,  OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h00000013, 1'b1, "fmt6"};
    vecs[15] = '{FMT_S, OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFFF7FF, 32'h7E20AFA3, 1'b1, "sw_small"};

    // Reset values
    #2 rst = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) run_one(vecs[i], 32'h1000);

    // start with count == 0
    start = 1'b1; base_addr = 32'h1000; count = 16'd0;
    step();
    start = 1'b0;
    chk("cnt0_done", done, 1);
    chk("cnt0_busy", busy, 0);
    step();
    chk("cnt0_done_low", done, 0);
    chk("cnt0_busy_low", busy, 0);

    // Backpressure with address wrap
    start = 1'b1; base_addr = 32'hFFFFFFF8; count = 16'd4;
    step();
    start = 1'b0;
    acc = 0;
    set_addi(0);
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      a = in_ready;
      step();
      if (a) begin acc++; set_addi(acc); end
      chk("bp_stall_data", out_data, 32'h00000093);
      chk("bp_stall_addr", out_addr, 32'hFFFFFFF8);
      chk("bp_stall_valid", out_valid, 1);
    end
    chk("bp_accepts", acc, 2);
    chk("bp_in_ready_full", in_ready, 0);
    stream(acc, 4, 32'hFFFFFFF8, "bp");
    chk("bp_err", err, 0);

    // start during RUN is ignored
    start = 1'b1; base_addr = 32'h2000; count = 16'd2;
    step();
    start = 1'b0;
    step();
    start = 1'b1; base_addr = 32'h3000; count = 16'd1;
    step();
    start = 1'b0;
    chk("rerun_busy", busy, 1);
    stream(0, 2, 32'h2000, "rerun");

    // Async reset with two words buffered
    start = 1'b1; base_addr = 32'h4000; count = 16'd4;
    step();
    start = 1'b0;
    set_addi(0);
    in_valid = 1'b1;
    step();
    set_addi(1);
    step();
    chk("rmid_pre_valid", out_valid, 1);
    chk("rmid_pre_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    in_valid = 1'b0;
    chk("rmid_out_valid", out_valid, 0);
    chk("rmid_in_ready", in_ready, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_addr", out_addr, 0);
    step();
    chk("rmid_done0", done, 0);
    rst = 1'b0;
    step();
    chk("rmid_done1", done, 0);
    chk("rmid_valid_after", out_valid, 0);
    run_one(vecs[0], 32'h5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_packer.md
Name: instr_packer

Overview:
- Write-side counterpart of the instruction field splitters; assembles RV32IM instruction words from discrete fields.
- Accepts field bundles (fmt, opcode, rd, rs1, rs2, funct3, funct7, imm) over a valid/ready handshake and packs each bundle into a 32-bit word.
- Buffers packed words in a 2-entry FIFO and streams them out with sequential word addresses.
- Used as the instruction-memory loader/self-test program generator ahead of the fetch stage.

Parameters:
- FIFO_DEPTH, 2, output buffer entries (power of two, minimum 2).
- CNT_W, 16, width of the instruction count and index counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE.
- base_addr  input  32  address of the first word; captured on start.
- count  input  CNT_W  number of words in the load; captured on start.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  bundle accepted when in_valid && in_ready.
- in_fmt  input  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J; 6 and 7 are illegal.
- in_opcode  input  7  opcode field.
- in_rd, in_rs1, in_rs2  input  5 each  register fields.
- in_funct3  input  3  funct3 field.
- in_funct7  input  7  funct7 field.
- in_imm  input  32  immediate value as a signed byte offset or value.
- out_valid  output  1  packed word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  32  packed instruction word.
- out_addr  output  32  address of out_data.
- done  output  1  one-cycle pulse when the last word is popped.
- err  output  1  sticky error flag; cleared on start.
- busy  output  1  high while not in IDLE.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; FIFO empty; counters 0.
  - Reset values: in_ready=0, out_valid=0, out_data=0, out_addr=0, done=0, err=0, busy=0.
  - Reset asserted mid-load discards all buffered words; no done pulse is generated.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE -> RUN on start with count != 0; base_addr and count are captured, and accepted, emitted and err are cleared.
  - IDLE with start and count == 0: done pulses on the next cycle; state stays IDLE.
  - RUN -> FLUSH when accepted == count.
  - FLUSH -> IDLE on the pop of the final word; done pulses in that same cycle (registered, high for 1 cycle).
  - start is ignored in RUN and FLUSH.
- in_ready = (state==RUN) && FIFO not full && accepted < count. Input has no combinational path to out_ready.
- Latency: a bundle accepted at edge N gives out_valid=1 with its word after edge N, i.e. 1 cycle.
- Output side:
  - out_addr = captured base + 4*emitted, computed modulo 2^32 (wrap allowed).
  - emitted increments on each out_valid && out_ready.
  - out_data and out_addr hold stable while out_valid && !out_ready.
- Simultaneous push and pop in the same cycle is allowed when the FIFO is not full. When the FIFO is full, in_ready=0 even if out_ready=1.
- Packing, with bit positions shown MSB to LSB:
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
  - I: imm[11:0] | rs1 | funct3 | rd | opcode.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode.
  - U: imm[31:12] | rd | opcode. imm[11:0] is ignored with no error.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode.
- Error conditions (all set err):
  - Illegal fmt (6 or 7): the word is replaced with 0x00000013 (NOP) and still counted.
  - B or J format with imm[0]=1: encoding proceeds with bit 0 dropped.
  - Immediate out of range, i.e. not sign-representable in the field width for I, S, B or J: the immediate is truncated.

Decomposition:
- Package rv_instr_pkg:
  - fmt_e enum (FMT_R..FMT_J).
  - Opcode localparams: OP_LUI=7'b0110111, OP_AUIPC, OP_JAL, OP_OP_IMM, OP_STORE, OP_BRANCH.
  - NOP_WORD=32'h00000013.
  - instr_fields_t packed struct.
- Sub-module instr_encoder: purely combinational; takes fields to word plus a range/alignment error bit. Shared with the splitters' verification as a golden model.
- The FIFO and FSM stay in instr_packer.

Test Plan:
- Single words, each with start, base_addr=0x1000, count=1:
  - U: opcode 0110111, rd=5, imm=0x12345000 -> out_data=0x123452B7, out_addr=0x1000, done 1 cycle after the pop, err=0.
  - I: ADDI x1,x0,1 (fmt I, opcode 0010011, funct3 0) -> 0x00100093.
  - S: SW x2,4(x1) (funct3 010) -> 0x0020A223.
  - J: JAL x1,+8 -> 0x008000EF.
- Backpressure: count=4, base_addr=0xFFFFFFF8, out_ready=0 for 5 cycles, in_valid held high:
  - in_ready drops after 2 accepts.
  - out_data and out_addr are stable while stalled.
  - Addresses are 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
  - Exactly one done pulse.
- Errors:
  - fmt=7 -> out_data=0x00000013, err=1 and stays set until the next start.
  - B with imm=3 -> err=1.
- Edge cases:
  - start with count=0 -> done the next cycle, busy stays 0.
  - start during RUN -> ignored.
- Reset: assert rst with 2 words buffered -> out_valid and in_ready fall immediately (async); no done; a subsequent load starts from the new base_addr.
